// File: rtl/spi_flash_cmd_engine_if.sv
// Command/stream handshake and SPI pin bundle for spi_flash_cmd_engine.
interface spi_flash_cmd_engine_if;
   logic        store_flash_command;
   logic [6:0]  wbuf_address;
   logic [31:0] flash_command;
   logic [11:0] flash_wr_nBits;
   logic        send_write_command;
   logic        end_write_command;
   logic        read_bitstream;
   logic        bitstream;
   logic        bitstream_valid;
   logic        end_bitstream;
   logic        spi_cs_n;
   logic        spi_sck_en;
   logic        spi_mosi;
   logic        spi_miso;
   logic        busy;
   logic        store_dropped;

   // Engine side
   modport slave (
      input  store_flash_command, wbuf_address, flash_command, flash_wr_nBits,
             send_write_command, read_bitstream, spi_miso,
      output end_write_command, bitstream, bitstream_valid, end_bitstream,
             spi_cs_n, spi_sck_en, spi_mosi, busy, store_dropped
   );

   // Requester / flash side
   modport master (
      output store_flash_command, wbuf_address, flash_command, flash_wr_nBits,
             send_write_command, read_bitstream, spi_miso,
      input  end_write_command, bitstream, bitstream_valid, end_bitstream,
             spi_cs_n, spi_sck_en, spi_mosi, busy, store_dropped
   );
endinterface

// File: rtl/spi_flash_cmd_engine.sv
// SPI flash master: shifts buffered write commands MSB-first and streams the
// bitstream read back from the flash, one bit per clk.
module spi_flash_cmd_engine #(
   parameter logic [31:0] BITSTREAM_BITS = 32'd5_464_640,
   parameter logic [5:0]  READ_CMD_BITS  = 6'd32
) (
   input logic                   clk,
   input logic                   reset_n,
   spi_flash_cmd_engine_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StWshift, StWend, StRshift, StRdata, StRend} state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;   // bits remaining minus one
   logic [6:0]  ptr_q, ptr_d;   // WBUF word being shifted
   logic [4:0]  pos_q, pos_d;   // bit position within word, 0 = MSB
   logic        bitstream_q, valid_q;
   logic [31:0] wbuf [128];
   logic [31:0] cur_word;
   logic        req;

   // Command buffer; contents survive reset, writes accepted only while idle
   always_ff @(posedge clk) begin
      if (bus.store_flash_command && state_q == StIdle) begin
         wbuf[bus.wbuf_address] <= bus.flash_command;
      end
   end

   // State and counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= '0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         pos_q   <= pos_d;
      end
   end

   // Next-state, counters and SPI pin outputs
   always_comb begin
      state_d               = state_q;
      cnt_d                 = cnt_q;
      ptr_d                 = ptr_q;
      pos_d                 = pos_q;
      cur_word              = wbuf[ptr_q];
      req                   = 1'b0;
      bus.spi_cs_n          = 1'b1;
      bus.spi_sck_en        = 1'b0;
      bus.spi_mosi          = 1'b0;
      bus.end_write_command = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.send_write_command) begin
               state_d = StWshift;
               cnt_d   = {20'd0, bus.flash_wr_nBits};
               ptr_d   = '0;
               pos_d   = '0;
            end else if (bus.read_bitstream) begin
               state_d = StRshift;
               cnt_d   = 32'(READ_CMD_BITS) - 32'd1;
               ptr_d   = '0;
               pos_d   = '0;
            end
         end
         StWshift, StRshift: begin
            req            = (state_q == StWshift) ? bus.send_write_command : bus.read_bitstream;
            bus.spi_cs_n   = 1'b0;
            bus.spi_sck_en = 1'b1;
            bus.spi_mosi   = cur_word[5'd31 - pos_q];
            pos_d          = pos_q + 5'd1;
            if (pos_q == 5'd31) ptr_d = ptr_q + 7'd1;
            cnt_d          = cnt_q - 32'd1;
            if (!req) begin
               state_d = StIdle;
            end else if (cnt_q == 32'd0) begin
               if (state_q == StWshift) begin
                  state_d = StWend;
               end else begin
                  state_d = StRdata;
                  cnt_d   = BITSTREAM_BITS - 32'd1;
               end
            end
         end
         StWend: begin
            bus.end_write_command = 1'b1;
            if (!bus.send_write_command) state_d = StIdle;
         end
         StRdata: begin
            bus.spi_cs_n   = 1'b0;
            bus.spi_sck_en = 1'b1;
            cnt_d          = cnt_q - 32'd1;
            if (!bus.read_bitstream) state_d = StIdle;
            else if (cnt_q == 32'd0) state_d = StRend;
         end
         StRend: begin
            if (!bus.read_bitstream) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Capture flash data; a bit sampled in the cycle the request drops is discarded
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bitstream_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         valid_q     <= (state_q == StRdata) && bus.read_bitstream;
         bitstream_q <= (state_q == StRdata) ? bus.spi_miso : 1'b0;
      end
   end

   // Status outputs; end_bitstream waits until the last data bit has been presented
   always_comb begin
      bus.busy            = (state_q != StIdle);
      bus.store_dropped   = bus.store_flash_command && (state_q != StIdle);
      bus.bitstream       = bitstream_q;
      bus.bitstream_valid = valid_q;
      bus.end_bitstream   = (state_q == StRend) && !valid_q;
   end

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// Bench for spi_flash_cmd_engine with a 64-bit stream and a simple flash model.
module tb_spi_flash_cmd_engine;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   spi_flash_cmd_engine_if bif ();

   spi_flash_cmd_engine #(
      .BITSTREAM_BITS (32'd64),
      .READ_CMD_BITS  (6'd32)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   logic [63:0] pat = 64'hA5C3_0F96_5A3C_F01E;

   // Flash model: counts SCK pulses per select, records the 32-bit command,
   // then drives data bits MSB-first, changing just after each SCK edge
   int          fl_cnt = 0;
   logic [31:0] fl_cmd = '0;
   always @(posedge clk) begin
      if (bif.spi_cs_n) begin
         fl_cnt <= 0;
      end else if (bif.spi_sck_en) begin
         if (fl_cnt < 32) fl_cmd <= {fl_cmd[30:0], bif.spi_mosi};
         fl_cnt <= fl_cnt + 1;
      end
   end
   always_comb begin
      bif.spi_miso = 1'b0;
      if (fl_cnt >= 32 && fl_cnt < 96) bif.spi_miso = pat[95 - fl_cnt];
   end

   // Free-running bus monitor
   logic [63:0] mosi_sr      = '0;
   int          sck_total    = 0;
   int          cs_low_total = 0;
   always @(posedge clk) begin
      if (!bif.spi_cs_n) begin
         cs_low_total <= cs_low_total + 1;
         if (bif.spi_sck_en) begin
            mosi_sr   <= {mosi_sr[62:0], bif.spi_mosi};
            sck_total <= sck_total + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] lowbits(input logic [63:0] v, input int n);
      if (n >= 64) return v;
      return v & ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [31:0] fw(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, b ^ 8'h5A, b + 8'd1};
   endfunction

   task automatic store(input logic [6:0] a, input logic [31:0] d);
      bif.wbuf_address        = a;
      bif.flash_command       = d;
      bif.store_flash_command = 1'b1;
      @(negedge clk);
      bif.store_flash_command = 1'b0;
   endtask

   task automatic do_write(input string tag, input logic [11:0] nbits,
                           input logic [63:0] exp, input int len);
      int s0, c0;
      bit seen;
      s0   = sck_total;
      c0   = cs_low_total;
      seen = 1'b0;
      bif.flash_wr_nBits     = nbits;
      bif.send_write_command = 1'b1;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(negedge clk);
         seen = bif.end_write_command;
      end
      chk({tag, "_end_seen"}, 64'(seen), 64'd1);
      repeat (3) @(negedge clk);
      chk({tag, "_end_held"}, {62'd0, bif.end_write_command, bif.spi_cs_n}, 64'd3);
      chk({tag, "_mosi"}, lowbits(mosi_sr, len), exp);
      chk({tag, "_sck"}, 64'(sck_total - s0), 64'(len));
      chk({tag, "_cs_low"}, 64'(cs_low_total - c0), 64'(len));
      bif.send_write_command = 1'b0;
      @(negedge clk);
      chk({tag, "_release"}, {62'd0, bif.busy, bif.end_write_command}, 64'd0);
   endtask

   task automatic do_read(input string tag, input int abort_at, input bit store_mid,
                          input int lat);
      int first_v, end_c, nval, nbad, cyc;
      bit done, aborted, ev;
      first_v = -1; end_c = -1; nval = 0; nbad = 0; cyc = 0;
      done = 1'b0; aborted = 1'b0;
      bif.read_bitstream = 1'b1;
      while (cyc < 400 && !done) begin
         @(negedge clk);
         cyc++;
         bif.store_flash_command = 1'b0;
         if (bif.bitstream_valid) begin
            if (first_v < 0) first_v = cyc;
            if (nval > 63 || bif.bitstream !== pat[63 - nval]) nbad++;
            nval++;
            if (store_mid && nval == 5) begin
               bif.wbuf_address        = 7'd0;
               bif.flash_command       = 32'hFFFF_FFFF;
               bif.store_flash_command = 1'b1;
               #1;
               chk({tag, "_store_dropped"}, 64'(bif.store_dropped), 64'd1);
            end
         end
         if (bif.end_bitstream) begin
            end_c = cyc;
            done  = 1'b1;
         end
         if (abort_at >= 0 && nval == abort_at) begin
            aborted = 1'b1;
            done    = 1'b1;
         end
      end
      chk({tag, "_cmd"}, 64'(fl_cmd), 64'h0301_0000);
      chk({tag, "_first_valid"}, 64'(first_v), 64'(34 + lat));
      chk({tag, "_bits_bad"}, 64'(nbad), 64'd0);
      if (aborted) begin
         bif.read_bitstream = 1'b0;
         @(negedge clk);
         chk({tag, "_abort_cs"}, {62'd0, bif.spi_cs_n, bif.busy}, 64'd2);
         ev = 1'b0;
         repeat (4) begin
            @(negedge clk);
            ev = ev | bif.end_bitstream | bif.bitstream_valid;
         end
         chk({tag, "_abort_no_end"}, 64'(ev), 64'd0);
      end else begin
         chk({tag, "_end_cycle"}, 64'(end_c), 64'(98 + lat));
         chk({tag, "_nvalid"}, 64'(nval), 64'd64);
         repeat (2) @(negedge clk);
         chk({tag, "_end_held"}, {62'd0, bif.end_bitstream, bif.spi_cs_n}, 64'd3);
         bif.read_bitstream = 1'b0;
         @(negedge clk);
         chk({tag, "_release"}, {62'd0, bif.busy, bif.end_bitstream}, 64'd0);
      end
   endtask

   typedef struct {
      logic [31:0] w0;
      logic [31:0] w1;
      logic [11:0] nbits;
      logic [63:0] exp;
      int          len;
   } wvec_t;

   wvec_t wv[5];

   initial begin
      wv[0] = '{32'h0600_0000, 32'h0000_0000, 12'd7,  64'h06,             8};
      wv[1] = '{32'hC501_0000, 32'h0000_0000, 12'd15, 64'hC501,           16};
      wv[2] = '{32'h9F12_3400, 32'h0000_0000, 12'd23, 64'h9F_1234,        24};
      wv[3] = '{32'hDEAD_BEEF, 32'h0000_0000, 12'd31, 64'hDEAD_BEEF,      32};
      wv[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 12'd39, 64'h12_3456_789A,   40};

      reset_n                 = 1'b0;
      bif.store_flash_command = 1'b0;
      bif.wbuf_address        = '0;
      bif.flash_command       = '0;
      bif.flash_wr_nBits      = '0;
      bif.send_write_command  = 1'b0;
      bif.read_bitstream      = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs",
          {56'd0, bif.spi_cs_n, bif.spi_sck_en, bif.spi_mosi, bif.busy,
           bif.end_write_command, bif.bitstream_valid, bif.end_bitstream, bif.bitstream},
          64'h80);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {62'd0, bif.spi_cs_n, bif.busy}, 64'd2);

      for (int v = 0; v < 5; v++) begin
         store(7'd0, wv[v].w0);
         store(7'd1, wv[v].w1);
         do_write($sformatf("wr%0d", v), wv[v].nbits, wv[v].exp, wv[v].len);
      end

      // Whole buffer: 4096 bits, last 64 on the wire are words 126 and 127
      for (int i = 0; i < 128; i++) store(7'(i), fw(i));
      do_write("wr_full", 12'd4095, {fw(126), fw(127)}, 4096);

      store(7'd0, 32'h0301_0000);
      do_read("rd", -1, 1'b0, 0);
      do_read("rd_abort", 10, 1'b0, 0);
      do_read("rd_restart", -1, 1'b0, 0);
      do_read("rd_store", -1, 1'b1, 0);
      do_write("wr_after_drop", 12'd31, 64'h0301_0000, 32);

      // Both requests: write first, read follows once send is released
      bif.read_bitstream = 1'b1;
      do_write("both_wr", 12'd7, 64'h03, 8);
      do_read("both_rd", -1, 1'b0, 0);

      // Asynchronous reset in the middle of a write
      store(7'd0, 32'hC501_0000);
      bif.flash_wr_nBits     = 12'd15;
      bif.send_write_command = 1'b1;
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset", {61'd0, bif.spi_cs_n, bif.busy, bif.spi_sck_en}, 64'd4);
      bif.send_write_command = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_write("wr_post_reset", 12'd15, 64'hC501, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
